br_scan_engine: RTL and testbench

Sequential initiator for the 32×32 register bank's read/write ports. Each `start` runs one full-bank transfer in one of two modes. In dump mode it walks the read address across the bank and streams each register out on a valid/ready interface. In load mode it accepts a valid/ready word stream and issues one registered, glitch-free write per word. It sits beside the register bank for debug snapshot/restore and context save, and is multiplexed onto the bank ports by the top level.

---
 rtl/br_scan_engine_if.sv | 35 +++
 rtl/br_scan_engine.sv | 131 +++++++++++++
 tb/tb_br_scan_engine.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/br_scan_engine_if.sv
// Bank-side bundle for br_scan_engine: start/mode control, bank read/write ports,
// and the dump/load valid-ready streams. master = engine, slave = surrounding logic.
interface br_scan_engine_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              start;
   logic              mode;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] rd_reg;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W-1:0] wr_reg;
   logic [DATA_W-1:0] wr_data;
   logic              reg_write;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_idx;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;

   modport master (
      input  start, mode, rd_data, out_ready, in_valid, in_data,
      output busy, done, rd_reg, wr_reg, wr_data, reg_write,
             out_valid, out_data, out_idx, in_ready
   );

   modport slave (
      output start, mode, rd_data, out_ready, in_valid, in_data,
      input  busy, done, rd_reg, wr_reg, wr_data, reg_write,
             out_valid, out_data, out_idx, in_ready
   );
endinterface

// File: rtl/br_scan_engine.sv
// Full-bank dump/load sequencer for the 32x32 register bank.
// Optional build macro BR_SCAN_SKIP_R0_EN excludes register 0 from every transfer.
module br_scan_engine #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   br_scan_engine_if.master bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DUMP = 2'd1,
      S_LOAD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
   localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
`ifdef BR_SCAN_SKIP_R0_EN
   localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
`else
   localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(0);
`endif

   state_t            r_state;
   logic [ADDR_W-1:0] r_idx;
   logic              r_fetch_pending;
   logic              r_busy;
   logic              r_done;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic [ADDR_W-1:0] r_out_idx;
   logic              r_in_ready;
   logic              r_reg_write;
   logic [ADDR_W-1:0] r_wr_reg;
   logic [DATA_W-1:0] r_wr_data;

   logic w_reload;
   logic w_accept;

   // A handshake without a reload can only be the final word: fetch_pending is already clear.
   assign w_reload = r_fetch_pending && (!r_out_valid || bus.out_ready);
   assign w_accept = bus.in_valid && r_in_ready;

   assign bus.rd_reg    = (r_state == S_DUMP) ? r_idx : {ADDR_W{1'b0}};
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_idx   = r_out_idx;
   assign bus.in_ready  = r_in_ready;
   assign bus.reg_write = r_reg_write;
   assign bus.wr_reg    = r_wr_reg;
   assign bus.wr_data   = r_wr_data;

   // Transfer FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_idx           <= {ADDR_W{1'b0}};
         r_fetch_pending <= 1'b0;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_out_valid     <= 1'b0;
         r_out_data      <= {DATA_W{1'b0}};
         r_out_idx       <= {ADDR_W{1'b0}};
         r_in_ready      <= 1'b0;
         r_reg_write     <= 1'b0;
         r_wr_reg        <= {ADDR_W{1'b0}};
         r_wr_data       <= {DATA_W{1'b0}};
      end else begin
         r_reg_write <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_idx  <= FIRST;
                  r_busy <= 1'b1;
                  if (bus.mode) begin
                     r_state    <= S_LOAD;
                     r_in_ready <= 1'b1;
                  end else begin
                     r_state         <= S_DUMP;
                     r_fetch_pending <= 1'b1;
                  end
               end
            end
            S_DUMP: begin
               if (w_reload) begin
                  r_out_data  <= bus.rd_data;
                  r_out_idx   <= r_idx;
                  r_out_valid <= 1'b1;
                  if (r_idx == LAST) begin
                     r_fetch_pending <= 1'b0;
                  end else begin
                     r_idx <= r_idx + ONE;
                  end
               end else if (r_out_valid && bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_DONE;
                  r_done      <= 1'b1;
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  r_reg_write <= 1'b1;
                  r_wr_reg    <= r_idx;
                  r_wr_data   <= bus.in_data;
                  if (r_idx == LAST) begin
                     r_in_ready <= 1'b0;
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                  end else begin
                     r_idx <= r_idx + ONE;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_br_scan_engine.sv
// Self-checking bench for br_scan_engine: bank memory model, stream scoreboards, randomized handshakes.
module tb_br_scan_engine;
   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
`ifdef BR_SCAN_SKIP_R0_EN
   localparam int FIRST = 1;
`else
   localparam int FIRST = 0;
`endif
   localparam int NWORDS = NUM_REGS - FIRST;
   localparam int BUDGET = 400;

   typedef struct {
      logic [ADDR_W-1:0] r;
      logic [DATA_W-1:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   br_scan_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   br_scan_engine #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [DATA_W-1:0] bank       [NUM_REGS];
   logic [DATA_W-1:0] preset_val [NUM_REGS];
   logic [DATA_W-1:0] exp_bank   [NUM_REGS];
   logic              do_preset = 1'b0;

   assign bus.rd_data = bank[bus.rd_reg];

   // Register bank: preset from the bench, otherwise written by the engine.
   always @(posedge clk) begin
      if (do_preset) begin
         for (int i = 0; i < NUM_REGS; i++) bank[i] <= preset_val[i];
      end else if (bus.reg_write) begin
         bank[bus.wr_reg] <= bus.wr_data;
      end
   end

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic preset(input bit rnd);
      for (int i = 0; i < NUM_REGS; i++) begin
         preset_val[i] = rnd ? DATA_W'($urandom) : DATA_W'(32'(i) * 32'h01010101);
         exp_bank[i]   = preset_val[i];
      end
      @(negedge clk) do_preset = 1'b1;
      @(negedge clk) do_preset = 1'b0;
   endtask

   task automatic check_bank(input string tag);
      for (int i = 0; i < NUM_REGS; i++) chk(tag, 64'(bank[i]), 64'(exp_bank[i]));
   endtask

   // rmode: 0 = ready always high, 1 = ready 1,0,0,1 repeating, 2 = random ready.
   task automatic run_dump(input int rmode, input bit inject);
      int                cyc = 0, exp_i = FIRST, first_valid = -1, last_hs = -1;
      bit                done_seen = 1'b0, prev_stall = 1'b0, injected = 1'b0, wrote = 1'b0;
      logic [DATA_W-1:0] prev_data = '0;
      logic [ADDR_W-1:0] prev_idx = '0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.mode  = 1'b0;
      while (!done_seen && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
         bus.start = 1'b0;
         bus.mode  = 1'b0;
         if (bus.reg_write) wrote = 1'b1;
         if (prev_stall) begin
            chk("dump_stall_valid", 64'(bus.out_valid), 64'(1));
            chk("dump_stall_data", 64'(bus.out_data), 64'(prev_data));
            chk("dump_stall_idx", 64'(bus.out_idx), 64'(prev_idx));
         end
         if (bus.done) begin
            done_seen = 1'b1;
            chk("dump_done_timing", 64'(cyc), 64'(last_hs + 1));
            chk("dump_busy_in_done", 64'(bus.busy), 64'(1));
         end else begin
            if (inject && !injected && bus.out_valid && bus.out_idx == ADDR_W'(10)) begin
               bus.start = 1'b1;
               bus.mode  = 1'b1;
               injected  = 1'b1;
            end
            case (rmode)
               0:       bus.out_ready = 1'b1;
               1:       bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
               default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (bus.out_valid && first_valid < 0) first_valid = cyc;
            if (bus.out_valid && bus.out_ready) begin
               chk("dump_idx", 64'(bus.out_idx), 64'(exp_i));
               chk("dump_data", 64'(bus.out_data), 64'(exp_bank[exp_i % NUM_REGS]));
               exp_i++;
               last_hs = cyc;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_idx   = bus.out_idx;
         end
      end
      bus.out_ready = 1'b0;
      chk("dump_finished", 64'(done_seen), 64'(1));
      chk("dump_word_count", 64'(exp_i - FIRST), 64'(NWORDS));
      chk("dump_first_valid_latency", 64'(first_valid), 64'(2));
      chk("dump_no_write", 64'(wrote), 64'(0));
      if (rmode == 0) chk("dump_back_to_back", 64'(last_hs - first_valid), 64'(NWORDS - 1));
      @(negedge clk);
      chk("dump_busy_after", 64'(bus.busy), 64'(0));
      chk("dump_done_after", 64'(bus.done), 64'(0));
   endtask

   // vmode: 0 = in_valid low every third cycle with 0xA0000000+i, 1 = random valid and data.
   // abort_at > 0: assert rst together with that accept number.
   task automatic run_load(input int vmode, input int abort_at);
      int                cyc = 0, n_acc = 0;
      bit                done_seen = 1'b0, acc_prev = 1'b0, stop = 1'b0;
      logic [DATA_W-1:0] word;
      wr_t               q[$];
      wr_t               e;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.mode     = 1'b1;
      bus.in_valid = 1'b0;
      while (!stop && !done_seen && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
         bus.start = 1'b0;
         bus.mode  = 1'b0;
         if (cyc == 1) chk("load_in_ready_first", 64'(bus.in_ready), 64'(1));
         chk("load_write_timing", 64'(bus.reg_write), 64'(acc_prev));
         if (bus.reg_write && q.size() > 0) begin
            e = q.pop_front();
            chk("load_wr_reg", 64'(bus.wr_reg), 64'(e.r));
            chk("load_wr_data", 64'(bus.wr_data), 64'(e.d));
            if (q.size() == 0 && n_acc == NWORDS) chk("load_done_with_last", 64'(bus.done), 64'(1));
         end
         if (bus.done) done_seen = 1'b1;
         word          = (vmode == 0) ? DATA_W'(32'hA0000000 + 32'(FIRST + n_acc)) : DATA_W'($urandom);
         bus.in_valid  = (vmode == 0) ? (cyc % 3 != 0) : 1'($urandom_range(0, 1));
         bus.in_data   = word;
         acc_prev      = bus.in_valid && bus.in_ready;
         if (acc_prev && abort_at > 0 && n_acc + 1 == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst          = 1'b0;
            bus.in_valid = 1'b0;
            chk("abort_reg_write", 64'(bus.reg_write), 64'(0));
            chk("abort_in_ready", 64'(bus.in_ready), 64'(0));
            chk("abort_busy", 64'(bus.busy), 64'(0));
            stop = 1'b1;
         end else if (acc_prev) begin
            e.r = ADDR_W'(FIRST + n_acc);
            e.d = word;
            q.push_back(e);
            exp_bank[FIRST + n_acc] = word;
            n_acc++;
         end
      end
      bus.in_valid = 1'b0;
      if (!stop) begin
         chk("load_finished", 64'(done_seen), 64'(1));
         chk("load_accept_count", 64'(n_acc), 64'(NWORDS));
         chk("load_pending_writes", 64'(q.size()), 64'(0));
         @(negedge clk);
         chk("load_busy_after", 64'(bus.busy), 64'(0));
         chk("load_in_ready_after", 64'(bus.in_ready), 64'(0));
      end
      @(negedge clk);
      check_bank(stop ? "abort_bank" : "load_bank");
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.mode      = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      rst           = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 64'(0));
      chk("rst_done", 64'(bus.done), 64'(0));
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
      chk("rst_reg_write", 64'(bus.reg_write), 64'(0));
      chk("rst_rd_reg", 64'(bus.rd_reg), 64'(0));
      rst = 1'b0;

      preset(1'b0);
      run_dump(0, 1'b0);
      run_dump(1, 1'b0);
      run_load(0, 0);
      run_dump(2, 1'b1);
      preset(1'b1);
      run_load(1, 0);
      run_dump(2, 1'b0);
      preset(1'b0);
      run_load(0, 12);
      run_dump(0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
